// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
// FSM state encodings, default data-cache wait limit, output bundle.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        BUBBLE = 2'b01,
        DWAIT  = 2'b10,
        IWAIT  = 2'b11
    } ctrl_state_e;

    localparam int unsigned MAX_WAIT_DEF = 255;

    typedef struct packed {
        logic pc_we;
        logic if_id_stall;
        logic id_ex_stall;
        logic ex_mem_stall;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_flush;
    } ctrl_out_t;

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard-event inputs and register-enable outputs of the stall sequencer.
// STALL_COUNTER_EN adds the stall_cycles performance counter.
interface pipeline_stall_controller_if;

    logic       load_use_hazard;
    logic       branch_taken;
    logic       icache_busy;
    logic       dcache_busy;
    logic       mem_access;
    logic       pc_write_en;
    logic       if_id_stall;
    logic       id_ex_stall;
    logic       ex_mem_stall;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       mem_wb_flush;
    logic [1:0] ctrl_state;
    logic       mem_timeout;
`ifdef STALL_COUNTER_EN
    logic [31:0] stall_cycles;
`endif

    modport master (
        output load_use_hazard, branch_taken, icache_busy,
        output dcache_busy, mem_access,
        input  pc_write_en, if_id_stall, id_ex_stall, ex_mem_stall,
        input  if_id_flush, id_ex_flush, mem_wb_flush,
`ifdef STALL_COUNTER_EN
        input  stall_cycles,
`endif
        input  ctrl_state, mem_timeout
    );

    modport slave (
        input  load_use_hazard, branch_taken, icache_busy,
        input  dcache_busy, mem_access,
        output pc_write_en, if_id_stall, id_ex_stall, ex_mem_stall,
        output if_id_flush, id_ex_flush, mem_wb_flush,
`ifdef STALL_COUNTER_EN
        output stall_cycles,
`endif
        output ctrl_state, mem_timeout
    );

endinterface

// File: rtl/stall_wait_timer.sv
// Saturating 8-bit data-cache wait counter with sticky timeout flag.
module stall_wait_timer #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic clear_i,
    output logic timeout_o
);

    localparam logic [7:0] MaxV = 8'(MAX_WAIT);

    logic [7:0] cnt_q, cnt_d;
    logic       to_q, to_d;

    always_comb begin
        cnt_d = cnt_q;
        to_d  = to_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && cnt_q != MaxV) begin
            cnt_d = cnt_q + 8'd1;
        end
        // Only a reset clears the flag; release just clears the count.
        if (inc_i && cnt_d == MaxV) begin
            to_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign timeout_o = to_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Prioritised stall/flush sequencer: D > B > I > L, Mealy outputs.
// STALL_COUNTER_EN adds a saturating count of PC-held cycles.
module pipeline_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    pipeline_stall_controller_if.slave  bus
);

    ctrl_state_e state_q, state_d;
    ctrl_out_t   o;
    logic        d_ev, l_ev, inc, clr;

    always_comb begin
        state_d  = state_q;
        o        = '0;
        o.pc_we  = 1'b1;
        inc      = 1'b0;
        clr      = 1'b0;
        // Inside DWAIT the access is already known to be a memory op.
        d_ev = (state_q == DWAIT) ? bus.dcache_busy
                                  : (bus.dcache_busy & bus.mem_access);
        l_ev = bus.load_use_hazard && (state_q != BUBBLE);
        if (state_q == DWAIT && !bus.dcache_busy) begin
            clr = 1'b1;
        end
        if (d_ev) begin
            o.pc_we        = 1'b0;
            o.if_id_stall  = 1'b1;
            o.id_ex_stall  = 1'b1;
            o.ex_mem_stall = 1'b1;
            o.mem_wb_flush = 1'b1;
            inc            = 1'b1;
            state_d        = DWAIT;
        end else if (bus.branch_taken) begin
            o.if_id_flush  = 1'b1;
            o.id_ex_flush  = 1'b1;
            state_d        = RUN;
        end else if (bus.icache_busy) begin
            o.pc_we        = 1'b0;
            o.if_id_flush  = 1'b1;
            state_d        = IWAIT;
        end else if (l_ev) begin
            o.pc_we        = 1'b0;
            o.if_id_stall  = 1'b1;
            o.id_ex_flush  = 1'b1;
            state_d        = BUBBLE;
        end else begin
            state_d        = RUN;
        end
        if (!reset) begin
            o = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    stall_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timer (
        .clk       (clk),
        .rst_n     (reset),
        .inc_i     (inc),
        .clear_i   (clr),
        .timeout_o (bus.mem_timeout)
    );

`ifdef STALL_COUNTER_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (!o.pc_we && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign bus.stall_cycles = stall_cnt_q;
`endif

    assign bus.pc_write_en  = o.pc_we;
    assign bus.if_id_stall  = o.if_id_stall;
    assign bus.id_ex_stall  = o.id_ex_stall;
    assign bus.ex_mem_stall = o.ex_mem_stall;
    assign bus.if_id_flush  = o.if_id_flush;
    assign bus.id_ex_flush  = o.id_ex_flush;
    assign bus.mem_wb_flush = o.mem_wb_flush;
    assign bus.ctrl_state   = state_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller (MAX_WAIT=4).
// Output vector order: pc_we,ifid_st,idex_st,exmem_st,ifid_fl,idex_fl,memwb_fl.
module tb_pipeline_stall_controller;

    localparam logic [6:0] O_ZERO = 7'b0000000;
    localparam logic [6:0] O_NORM = 7'b1000000;
    localparam logic [6:0] O_D    = 7'b0111001;
    localparam logic [6:0] O_B    = 7'b1000110;
    localparam logic [6:0] O_I    = 7'b0000100;
    localparam logic [6:0] O_L    = 7'b0100010;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    pipeline_stall_controller_if bus ();

    pipeline_stall_controller #(
        .MAX_WAIT (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {bus.pc_write_en, bus.if_id_stall, bus.id_ex_stall,
                bus.ex_mem_stall, bus.if_id_flush, bus.id_ex_flush,
                bus.mem_wb_flush};
    endfunction

    task automatic drive(input logic d, m, b, i, l);
        bus.dcache_busy     = d;
        bus.mem_access      = m;
        bus.branch_taken    = b;
        bus.icache_busy     = i;
        bus.load_use_hazard = l;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1, 1, 1, 1, 1);
        n_chk++;
        if (outs() !== O_ZERO) begin
            n_fail++;
            $display("FAIL rst_outs got=%b exp=%b", outs(), O_ZERO);
        end
        n_chk++;
        if (bus.ctrl_state !== 2'b00 || bus.mem_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_state got=%b/%b exp=00/0",
                     bus.ctrl_state, bus.mem_timeout);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        n_chk++;
        if (outs() !== O_NORM || bus.ctrl_state !== 2'b00) begin
            n_fail++;
            $display("FAIL idle got=%b/%b exp=%b/00",
                     outs(), bus.ctrl_state, O_NORM);
        end
    endtask

    task automatic test_load_use();
        logic [6:0] eo [2] = '{O_L, O_NORM};
        logic [1:0] es [2] = '{2'b01, 2'b00};
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 1);
            n_chk++;
            if (outs() !== eo[k]) begin
                n_fail++;
                $display("FAIL lu_outs[%0d] got=%b exp=%b", k, outs(), eo[k]);
            end
            tick();
            n_chk++;
            if (bus.ctrl_state !== es[k]) begin
                n_fail++;
                $display("FAIL lu_state[%0d] got=%b exp=%b",
                         k, bus.ctrl_state, es[k]);
            end
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_dwait();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k < 3) drive(1, 1, 0, 0, 0);
            else       drive(0, 0, 0, 0, 0);
            n_chk++;
            if (outs() !== ((k < 3) ? O_D : O_NORM)) begin
                n_fail++;
                $display("FAIL dw_outs[%0d] got=%b", k, outs());
            end
            tick();
            n_chk++;
            if (bus.ctrl_state !== ((k < 3) ? 2'b10 : 2'b00)) begin
                n_fail++;
                $display("FAIL dw_state[%0d] got=%b", k, bus.ctrl_state);
            end
        end
        n_chk++;
        if (bus.mem_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL dw_timeout got=%b exp=0", bus.mem_timeout);
        end
    endtask

    task automatic test_branch_icache();
        @(negedge clk);
        drive(0, 0, 1, 1, 0);
        n_chk++;
        if (outs() !== O_B) begin
            n_fail++;
            $display("FAIL bi_outs got=%b exp=%b", outs(), O_B);
        end
        tick();
        n_chk++;
        if (bus.ctrl_state !== 2'b00) begin
            n_fail++;
            $display("FAIL bi_state got=%b exp=00", bus.ctrl_state);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k < 2) drive(0, 0, 0, 1, 0);
            else       drive(0, 0, 0, 0, 0);
            n_chk++;
            if (outs() !== ((k < 2) ? O_I : O_NORM)) begin
                n_fail++;
                $display("FAIL iw_outs[%0d] got=%b", k, outs());
            end
            tick();
            n_chk++;
            if (bus.ctrl_state !== ((k < 2) ? 2'b11 : 2'b00)) begin
                n_fail++;
                $display("FAIL iw_state[%0d] got=%b", k, bus.ctrl_state);
            end
        end
    endtask

    task automatic test_d_over_b();
        @(negedge clk);
        drive(1, 1, 1, 0, 1);
        n_chk++;
        if (outs() !== O_D) begin
            n_fail++;
            $display("FAIL db_outs got=%b exp=%b", outs(), O_D);
        end
        tick();
        n_chk++;
        if (bus.ctrl_state !== 2'b10) begin
            n_fail++;
            $display("FAIL db_state got=%b exp=10", bus.ctrl_state);
        end
        @(negedge clk);
        drive(0, 0, 1, 0, 0);
        n_chk++;
        if (outs() !== O_B) begin
            n_fail++;
            $display("FAIL db_rel got=%b exp=%b", outs(), O_B);
        end
        tick();
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_timeout();
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            drive(1, 1, 0, 0, 0);
            tick();
            n_chk++;
            if (bus.mem_timeout !== ((k >= 4) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL to_flag[%0d] got=%b", k, bus.mem_timeout);
            end
        end
        n_chk++;
        if (outs() !== O_D || bus.ctrl_state !== 2'b10) begin
            n_fail++;
            $display("FAIL to_wait got=%b/%b", outs(), bus.ctrl_state);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        tick();
        n_chk++;
        if (bus.mem_timeout !== 1'b1 || bus.ctrl_state !== 2'b00) begin
            n_fail++;
            $display("FAIL to_sticky got=%b/%b exp=1/00",
                     bus.mem_timeout, bus.ctrl_state);
        end
        @(negedge clk);
        drive(1, 1, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_chk++;
        if (bus.ctrl_state !== 2'b00 || bus.mem_timeout !== 1'b0
            || outs() !== O_ZERO) begin
            n_fail++;
            $display("FAIL to_rst got=%b/%b/%b exp=00/0/%b",
                     bus.ctrl_state, bus.mem_timeout, outs(), O_ZERO);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
    endtask

`ifdef STALL_COUNTER_EN
    task automatic test_stall_counter();
        @(negedge clk);
        reset = 1'b0;
        #1;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 1);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k < 3) drive(1, 1, 0, 0, 0);
            else       drive(0, 0, 0, 0, 0);
        end
        tick();
        n_chk++;
        if (bus.stall_cycles !== 32'd4) begin
            n_fail++;
            $display("FAIL stall_cnt got=%0d exp=4", bus.stall_cycles);
        end
    endtask
`endif

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_load_use();
        test_dwait();
        test_branch_icache();
        test_d_over_b();
        test_timeout();
`ifdef STALL_COUNTER_EN
        test_stall_counter();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
